seq_addn: RTL and testbench

Parametrised multi-cycle adder that adds two WIDTH-bit operands CHUNK bits per clock. A carry register links each chunk to the next, so a wide add uses one narrow adder slice instead of a full-width combinational carry chain. It sits on the datapath wherever a wide add is needed but timing cannot close across WIDTH bits. It uses a valid/ready handshake on both input and output.

---
 rtl/seq_addn_if.sv | 37 +++
 rtl/seq_addn.sv | 101 ++++++++++
 tb/tb_seq_addn.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_addn_if.sv
// Operand/result handshake bundle for seq_addn. The sub signal exists only
// when SEQ_ADDN_SUB_EN is defined.
interface seq_addn_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SEQ_ADDN_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin,
`ifdef SEQ_ADDN_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef SEQ_ADDN_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/seq_addn.sv
// Multi-cycle adder: WIDTH-bit add done CHUNK bits per clock through a 1-bit carry register.
// Optional subtract mode is enabled by defining SEQ_ADDN_SUB_EN.
module seq_addn #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_addn_if.slave bus_io
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic             sub_eff;
  logic             accept;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   add_w;
  logic [CHUNK-1:0] sum_d;
  logic             carry_d;
  logic             msb_cin;

`ifdef SEQ_ADDN_SUB_EN
  assign sub_eff = bus_io.sub;
`else
  assign sub_eff = 1'b0;
`endif

  assign bus_io.in_ready = (state_q == IDLE) || ((state_q == DONE) && bus_io.out_ready);
  assign accept          = bus_io.in_valid && bus_io.in_ready;

  always_comb begin
    a_sl    = a_q[cnt_q*CHUNK +: CHUNK];
    b_sl    = b_q[cnt_q*CHUNK +: CHUNK];
    add_w   = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
    sum_d   = add_w[CHUNK-1:0];
    carry_d = add_w[CHUNK];
    // carry into the slice MSB, recovered from the sum bit; only used on the last slice
    msb_cin = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ sum_d[CHUNK-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      // reached from IDLE, or from DONE on the same edge the result is taken
      a_q         <= bus_io.a;
      b_q         <= bus_io.b ^ {WIDTH{sub_eff}};
      carry_q     <= bus_io.cin ^ sub_eff;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      state_q     <= RUN;
    end else begin
      case (state_q)
        RUN: begin
          s_q[cnt_q*CHUNK +: CHUNK] <= sum_d;
          carry_q                   <= carry_d;
          cnt_q                     <= cnt_q + 1'b1;
          if (cnt_q == CW'(NCHUNK - 1)) begin
            cout_q      <= carry_d;
            ovf_q       <= msb_cin ^ carry_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus_io.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_io.out_valid = out_valid_q;
  assign bus_io.s         = s_q;
  assign bus_io.cout      = cout_q;
  assign bus_io.ovf       = ovf_q;
endmodule

// File: tb/tb_seq_addn.sv
// Directed self-checking bench for seq_addn (WIDTH=32, CHUNK=8); subtract vectors
// are included when SEQ_ADDN_SUB_EN is defined.
module tb_seq_addn;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seq_addn_if #(.WIDTH(WIDTH)) bus ();

  seq_addn #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] exp_s;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.a   = v.a;
    bus.b   = v.b;
    bus.cin = v.cin;
`ifdef SEQ_ADDN_SUB_EN
    bus.sub = v.sub;
`endif
  endtask

  // From posedge+#1: present v, accept on next edge, count edges to out_valid.
  task automatic start_and_wait(input vec_t v, output int lat);
    drive(v);
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("out_valid_after_consume", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat;
    vec_t v;
    logic [31:0] held_s;
    int   res_cyc[$];
    logic [31:0] res_s[$];
    int   idx;
    int   seen;

    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 1'b0, 1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
    vecs.push_back('{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0});
`ifdef SEQ_ADDN_SUB_EN
    vecs.push_back('{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0});
`endif

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
`ifdef SEQ_ADDN_SUB_EN
    bus.sub       = 1'b0;
`endif

    // reset
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_s",         64'(bus.s),         64'd0);
    check("rst_cout",      64'(bus.cout),      64'd0);
    check("rst_ovf",       64'(bus.ovf),       64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    @(posedge clk); #1;

    // table-driven vectors
    foreach (vecs[i]) begin
      start_and_wait(vecs[i], lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
      check($sformatf("v%0d_s", i),    64'(bus.s),    64'(vecs[i].exp_s));
      check($sformatf("v%0d_cout", i), 64'(bus.cout), 64'(vecs[i].exp_cout));
      check($sformatf("v%0d_ovf", i),  64'(bus.ovf),  64'(vecs[i].exp_ovf));
      consume();
    end

    // backpressure in DONE with a pending operand set
    start_and_wait(vecs[4], lat);
    check("bp_latency", 64'(lat), 64'd4);
    held_s = bus.s;
    check("bp_s_initial", 64'(held_s), 64'(vecs[4].exp_s));
    @(posedge clk); #1;
    drive(vecs[2]);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp_out_valid_c%0d", c), 64'(bus.out_valid), 64'd1);
      check($sformatf("bp_in_ready_c%0d", c),  64'(bus.in_ready),  64'd0);
      check($sformatf("bp_s_c%0d", c),         64'(bus.s),         64'(vecs[4].exp_s));
      check($sformatf("bp_cout_ovf_c%0d", c),  64'({bus.cout, bus.ovf}),
            64'({vecs[4].exp_cout, vecs[4].exp_ovf}));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_release", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk);
      lat++;
    end
    check("bp_next_latency", 64'(lat), 64'd4);
    check("bp_next_s",   64'(bus.s),   64'(vecs[2].exp_s));
    check("bp_next_ovf", 64'(bus.ovf), 64'(vecs[2].exp_ovf));
    consume();

    // continuous streaming, 4 operand sets
    idx  = 0;
    seen = 0;
    drive(vecs[idx]);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 60 && seen < 4; c++) begin
      logic acc;
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        res_cyc.push_back(c);
        res_s.push_back(bus.s);
        seen++;
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 4) drive(vecs[idx]);
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("stream_count", 64'(res_s.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < res_s.size())
        check($sformatf("stream_s%0d", k), 64'(res_s[k]), 64'(vecs[k].exp_s));
    end
    for (int k = 1; k < 4; k++) begin
      if (k < res_cyc.size())
        check($sformatf("stream_gap%0d", k), 64'(res_cyc[k] - res_cyc[k-1]), 64'd5);
    end
    @(posedge clk); #1;

    // reset during the second RUN cycle
    v = vecs[4];
    drive(v);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_s",         64'(bus.s),         64'd0);
    check("midrst_cout",      64'(bus.cout),      64'd0);
    check("midrst_ovf",       64'(bus.ovf),       64'd0);
    check("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    seen = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    bus.out_ready = 1'b0;
    check("midrst_no_result", 64'(seen), 64'd0);

    // block still works after the abandoned operation
    @(posedge clk); #1;
    start_and_wait(vecs[1], lat);
    check("post_rst_latency", 64'(lat), 64'd4);
    check("post_rst_s", 64'(bus.s), 64'(vecs[1].exp_s));
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
